// File: rtl/lock_access_ctrl.sv
// Keypad lock session controller: round-robin arbiter for two keypads, code entry, fail counting, lockout.
// Optional LOCK_ALARM_LATCH_EN: once lockout expires the alarm and LOCKOUT state hold until reset.
module lock_access_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DW          = 3,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned UNLOCK_CYC  = 10,
  parameter int unsigned LOCKOUT_CYC = 50,
  parameter int unsigned IDLE_TO     = 20
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DIGITS*DW-1:0]            code,
  input  logic [1:0]                      req,
  input  logic [1:0]                      key_valid,
  input  logic [2*DW-1:0]                 key_digit,
  output logic [1:0]                      grant,
  output logic [1:0]                      key_ready,
  output logic [$clog2(DIGITS)-1:0]       sel,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic                            locked,
  output logic                            entimer,
  output logic                            alarm
);

  localparam int unsigned SW   = $clog2(DIGITS);
  localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
  localparam int unsigned T1   = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int unsigned TMAX = (T1 > IDLE_TO) ? T1 : IDLE_TO;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_UNLOCK, S_FAIL, S_LOCKOUT
  } state_t;

  state_t          state, state_n;
  logic [1:0]      grant_n, kr_n;
  logic [SW-1:0]   sel_n;
  logic [FW-1:0]   fail_n, fail_sat;
  logic            locked_n, ent_n, alarm_n;
  logic            mismatch, mm_n;
  logic [TW-1:0]   timer, tmr_n, tmr_inc;
  logic            rr, rr_n, pick;
  logic            own, accept;
  logic [DW-1:0]   digit, exp_digit;

  // Owner index and the digit it presents; the other keypad is never looked at.
  assign own       = grant[1];
  assign accept    = key_valid[own] & key_ready[own];
  assign digit     = own ? key_digit[2*DW-1:DW] : key_digit[DW-1:0];
  assign exp_digit = code[int'(sel)*DW +: DW];
  assign tmr_inc   = timer + TW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      grant     <= 2'b00;
      key_ready <= 2'b00;
      sel       <= '0;
      fail_cnt  <= '0;
      locked    <= 1'b1;
      entimer   <= 1'b0;
      alarm     <= 1'b0;
      mismatch  <= 1'b0;
      timer     <= '0;
      rr        <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      key_ready <= kr_n;
      sel       <= sel_n;
      fail_cnt  <= fail_n;
      locked    <= locked_n;
      entimer   <= ent_n;
      alarm     <= alarm_n;
      mismatch  <= mm_n;
      timer     <= tmr_n;
      rr        <= rr_n;
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    kr_n     = key_ready;
    sel_n    = sel;
    fail_n   = fail_cnt;
    locked_n = locked;
    ent_n    = entimer;
    alarm_n  = alarm;
    mm_n     = mismatch;
    tmr_n    = timer;
    rr_n     = rr;
    pick     = 1'b0;
    fail_sat = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + FW'(1);

    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          // rr names the keypad favoured on contention; it flips away from each winner
          pick    = (req == 2'b11) ? rr : req[1];
          grant_n = pick ? 2'b10 : 2'b01;
          kr_n    = pick ? 2'b10 : 2'b01;
          rr_n    = ~pick;
          sel_n   = '0;
          mm_n    = 1'b0;
          tmr_n   = '0;
          state_n = S_ENTRY;
        end
      end

      S_ENTRY: begin
        mm_n = mismatch | (accept & (digit != exp_digit));
        if (accept && sel == SW'(DIGITS - 1)) begin
          state_n = S_CHECK;
          grant_n = 2'b00;
          kr_n    = 2'b00;
          sel_n   = '0;
          tmr_n   = '0;
        end else if (!accept && tmr_inc == TW'(IDLE_TO)) begin
          state_n = S_FAIL;
          grant_n = 2'b00;
          kr_n    = 2'b00;
          sel_n   = '0;
          tmr_n   = '0;
        end else if (!req[own]) begin
          state_n = S_IDLE;
          grant_n = 2'b00;
          kr_n    = 2'b00;
          sel_n   = '0;
          tmr_n   = '0;
        end else if (accept) begin
          sel_n = sel + SW'(1);
          tmr_n = '0;
        end else begin
          tmr_n = tmr_inc;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          state_n = S_FAIL;
        end else begin
          state_n  = S_UNLOCK;
          fail_n   = '0;
          locked_n = 1'b0;
          ent_n    = 1'b1;
          tmr_n    = '0;
        end
      end

      S_UNLOCK: begin
        if (tmr_inc == TW'(UNLOCK_CYC)) begin
          state_n  = S_IDLE;
          locked_n = 1'b1;
          ent_n    = 1'b0;
          tmr_n    = '0;
        end else begin
          tmr_n = tmr_inc;
        end
      end

      S_FAIL: begin
        fail_n = fail_sat;
        if (fail_sat == FW'(MAX_FAIL)) begin
          state_n = S_LOCKOUT;
          alarm_n = 1'b1;
          tmr_n   = '0;
        end else begin
          state_n = S_IDLE;
        end
      end

      S_LOCKOUT: begin
`ifdef LOCK_ALARM_LATCH_EN
        // Timer parks at the limit; only reset leaves this state
        if (timer != TW'(LOCKOUT_CYC)) tmr_n = tmr_inc;
`else
        if (tmr_inc == TW'(LOCKOUT_CYC)) begin
          state_n = S_IDLE;
          alarm_n = 1'b0;
          fail_n  = '0;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr_inc;
        end
`endif
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Scoreboard bench for lock_access_ctrl: stimulus queues expected output vectors (and run lengths);
// a negedge monitor pops one entry per observed output change and compares.
module tb_lock_access_ctrl;
  localparam int unsigned DW = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] code;
  logic [1:0]  req, key_valid;
  logic [5:0]  key_digit;
  logic [1:0]  grant, key_ready, sel, fail_cnt;
  logic        locked, entimer, alarm;

  lock_access_ctrl dut (
    .clk(clk), .reset(reset), .code(code), .req(req), .key_valid(key_valid),
    .key_digit(key_digit), .grant(grant), .key_ready(key_ready), .sel(sel),
    .fail_cnt(fail_cnt), .locked(locked), .entimer(entimer), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [10:0] v; int len; } rec_t;
  rec_t expq[$];
  int n_chk = 0, n_pass = 0, n_rec = 0;

  // {grant, key_ready, sel, fail_cnt, locked, entimer, alarm}; key_ready always equals grant
  function automatic logic [10:0] mk(input logic [1:0] g, input logic [1:0] s, input logic [1:0] fc,
                                     input logic l, input logic e, input logic a);
    return {g, g, s, fc, l, e, a};
  endfunction

  function automatic logic [10:0] idle_v(input logic [1:0] fc);
    return mk(2'b00, 2'b00, fc, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic push(input logic [10:0] v, input int len);
    rec_t r;
    r.id = n_rec; r.v = v; r.len = len;
    n_rec++;
    expq.push_back(r);
  endtask

  // Four ENTRY vectors for a full code entry by owner g
  task automatic push_entry(input logic [1:0] g, input logic [1:0] fc, input int n);
    for (int i = 0; i < n; i++) push(mk(g, 2'(i), fc, 1'b1, 1'b0, 1'b0), 0);
  endtask

  // Monitor: one comparison per output change, plus a run-length check when requested
  logic [10:0] prev_v = 'x;
  logic [10:0] cur_v;
  int run = 0, pend_len = 0, pend_id = 0;
  rec_t mr;
  always @(negedge clk) begin
    cur_v = {grant, key_ready, sel, fail_cnt, locked, entimer, alarm};
    if (cur_v !== prev_v) begin
      if (pend_len != 0) begin
        n_chk++;
        if (run == pend_len) n_pass++;
        else $display("FAIL dur rec%0d: got %0d cycles, want %0d", pend_id, run, pend_len);
      end
      pend_len = 0;
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected change: got %b, want no change", cur_v);
      end else begin
        mr = expq.pop_front();
        n_chk++;
        if (cur_v === mr.v) n_pass++;
        else $display("FAIL out rec%0d: got %b, want %b", mr.id, cur_v, mr.v);
        pend_len = mr.len;
        pend_id  = mr.id;
      end
      run    = 1;
      prev_v = cur_v;
    end else begin
      run++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return key_ready[0];
      1:       return key_ready[1];
      2:       return alarm;
      3:       return ~locked;
      default: return ~key_ready[0];
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string what);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (probe(which) === 1'b1) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got no event, want it within %0d cycles", what, budget);
  endtask

  // Request, wait for ownership, present n digits on consecutive cycles
  task automatic session(input int k, input logic [11:0] digs, input int n, input bit drop);
    req[k] = 1'b1;
    wait_for(k, 40, "grant");
    for (int i = 0; i < n; i++) begin
      key_valid[k] = 1'b1;
      key_digit[k*DW +: DW] = digs[i*DW +: DW];
      tick(1);
    end
    key_valid[k] = 1'b0;
    if (drop) req[k] = 1'b0;
  endtask

  localparam logic [11:0] CODE_A = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [11:0] WRONG  = {3'd3, 3'd5, 3'd1, 3'd0};
  localparam logic [11:0] CODE_F = {3'd4, 3'd7, 3'd2, 3'd5};
  localparam logic [10:0] UNL    = {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
  localparam logic [10:0] LOCK   = {2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1};

  initial begin
    code = CODE_A; req = 2'b00; key_valid = 2'b00; key_digit = '0;
    push(idle_v(2'd0), 0);
    tick(3);
    reset = 1'b0;
    tick(2);

    // Correct code on keypad 0
    push_entry(2'b01, 2'd0, 4);
    push(idle_v(2'd0), 1);
    push(UNL, 10);
    push(idle_v(2'd0), 0);
    session(0, CODE_A, 4, 1'b1);
    tick(15);

    // Wrong third digit: all four consumed, then CHECK+FAIL, fail_cnt 1
    push_entry(2'b01, 2'd0, 4);
    push(idle_v(2'd0), 2);
    push(idle_v(2'd1), 0);
    session(0, WRONG, 4, 1'b1);
    tick(6);

    // Two more failures reach lockout; requests during lockout are ignored
    push_entry(2'b01, 2'd1, 4);
    push(idle_v(2'd1), 2);
    push(idle_v(2'd2), 0);
    session(0, WRONG, 4, 1'b1);
    tick(6);
    push_entry(2'b01, 2'd2, 4);
    push(idle_v(2'd2), 2);
`ifdef LOCK_ALARM_LATCH_EN
    push(LOCK, 81);
`else
    push(LOCK, 50);
`endif
    push(idle_v(2'd0), 0);
    session(0, WRONG, 4, 1'b1);
    wait_for(2, 20, "alarm");
    req = 2'b11; key_valid = 2'b11; key_digit = {3'd0, 3'd0};
    tick(30);
    req = 2'b00; key_valid = 2'b00;
`ifdef LOCK_ALARM_LATCH_EN
    tick(50);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
`else
    tick(25);
`endif

    // Arbitration from reset: keypad 0 first, then keypad 1; keypad 1 strobes ignored meanwhile
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    push_entry(2'b01, 2'd0, 4);
    push(idle_v(2'd0), 1);
    push(UNL, 10);
    push(idle_v(2'd0), 1);
    push_entry(2'b10, 2'd0, 4);
    push(idle_v(2'd0), 1);
    push(UNL, 10);
    push(idle_v(2'd0), 0);
    req = 2'b11; key_valid[1] = 1'b1; key_digit[5:3] = 3'd7;
    session(0, CODE_A, 4, 1'b0);
    key_valid[1] = 1'b0;
    session(1, CODE_A, 4, 1'b0);
    req = 2'b00;
    tick(15);

    // Timeout after two digits: 20 idle cycles, FAIL, fail_cnt 1
    push_entry(2'b01, 2'd0, 3);
    mr.id = 0;
    expq[expq.size()-1].len = 20;
    push(idle_v(2'd0), 1);
    push(idle_v(2'd1), 0);
    session(0, CODE_A, 2, 1'b0);
    wait_for(4, 40, "timeout");
    req = 2'b00;
    tick(5);

    // Abandon after two digits: back to IDLE, fail_cnt unchanged
    push_entry(2'b01, 2'd1, 3);
    push(idle_v(2'd1), 0);
    session(0, CODE_A, 2, 1'b1);
    tick(5);

    // Different code, then reset mid-UNLOCK
    code = CODE_F;
    push_entry(2'b01, 2'd1, 4);
    push(idle_v(2'd1), 1);
    push(UNL, 4);
    push(idle_v(2'd0), 0);
    session(0, CODE_F, 4, 1'b1);
    wait_for(3, 20, "unlock");
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(5);

    n_chk++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", expq.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
